// File: rtl/subs3_serial_if.sv
`timescale 1ns/1ps
// Operand/result handshake bundle for subs3_serial.
// Flag signals exist only when SUBS3_FLAGS_EN is defined.
interface subs3_serial_if #(
    parameter int W1 = 4,
    parameter int W2 = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [W1-1:0] a;
    logic [W1-1:0] b;
    logic [W2-1:0] c;
    logic [W2-1:0] d;
    logic          out_valid;
    logic          out_ready;
    logic [W1:0]   diff1;
    logic [W2:0]   diff2;
    logic [W2+1:0] diff3;
`ifdef SUBS3_FLAGS_EN
    logic          neg1;
    logic          neg2;
    logic          neg3;
    logic          zero3;
`endif

    modport master (
        output in_valid, a, b, c, d, out_ready,
        input  in_ready, out_valid, diff1, diff2, diff3
`ifdef SUBS3_FLAGS_EN
        , input neg1, neg2, neg3, zero3
`endif
    );

    modport slave (
        input  in_valid, a, b, c, d, out_ready,
        output in_ready, out_valid, diff1, diff2, diff3
`ifdef SUBS3_FLAGS_EN
        , output neg1, neg2, neg3, zero3
`endif
    );
endinterface

// File: rtl/subs3_serial.sv
`timescale 1ns/1ps
// Bit-serial a-b, c-d and (c-d)-(a-b): one full-subtractor cell per lane, one bit per clock.
// Optional sign/zero flag outputs are built when SUBS3_FLAGS_EN is defined.
module subs3_serial #(
    parameter int W1 = 4,
    parameter int W2 = 8
) (
    input  logic          clk,
    input  logic          reset,
    subs3_serial_if.slave bus
);
    localparam int D1W = W1 + 1;
    localparam int D2W = W2 + 1;
    localparam int D3W = W2 + 2;
    localparam int CW  = $clog2(D3W);
    localparam logic [CW-1:0] LAST1 = CW'(W1);
    localparam logic [CW-1:0] LAST2 = CW'(W2);
    localparam logic [CW-1:0] LAST3 = CW'(W2 + 1);

    typedef enum logic [1:0] {IDLE, SUB12, SUB3, DONE} state_t;

    state_t         state_reg, state_next;
    logic [D3W-1:0] a_reg, b_reg, c_reg, d_reg;
    logic [CW-1:0]  cnt_reg;
    logic           borrow1_reg, borrow2_reg, borrow3_reg;
    logic [D1W-1:0] sh1_reg;
    logic [D2W-1:0] sh2_reg;
    logic [D3W-1:0] sh3_reg;
    logic [D1W-1:0] diff1_reg;
    logic [D2W-1:0] diff2_reg;
    logic [D3W-1:0] diff3_reg;
    logic [D3W-1:0] x1_ext, x2_ext;
    logic [1:0]     s1, s2, s3;
    logic [D3W-1:0] sh3_final;
    logic           lane1_active;
    logic           in_ready_c, out_valid_c;

    // {borrow_out, difference}
    function automatic logic [1:0] fsub(input logic x, input logic y, input logic bin);
        return {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
    endfunction

    // Sign-extend both shadows to the diff3 width for the second pass
    generate
        for (genvar gi = 0; gi < D3W; gi++) begin : g_sext
            if (gi < D1W) begin : g_in1
                assign x1_ext[gi] = sh1_reg[gi];
            end else begin : g_ext1
                assign x1_ext[gi] = sh1_reg[D1W-1];
            end
            if (gi < D2W) begin : g_in2
                assign x2_ext[gi] = sh2_reg[gi];
            end else begin : g_ext2
                assign x2_ext[gi] = sh2_reg[D2W-1];
            end
        end
    endgenerate

    assign s1           = fsub(a_reg[cnt_reg], b_reg[cnt_reg], borrow1_reg);
    assign s2           = fsub(c_reg[cnt_reg], d_reg[cnt_reg], borrow2_reg);
    assign s3           = fsub(x2_ext[cnt_reg], x1_ext[cnt_reg], borrow3_reg);
    assign sh3_final    = {s3[0], sh3_reg[D3W-1:1]};
    assign lane1_active = (cnt_reg <= LAST1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = SUB12;
            end
            SUB12: if (cnt_reg == LAST2) state_next = SUB3;
            SUB3:  if (cnt_reg == LAST3) state_next = DONE;
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SUBS3_FLAGS_EN
    logic neg1_reg, neg2_reg, neg3_reg, zero3_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            d_reg       <= '0;
            cnt_reg     <= '0;
            borrow1_reg <= 1'b0;
            borrow2_reg <= 1'b0;
            borrow3_reg <= 1'b0;
            sh1_reg     <= '0;
            sh2_reg     <= '0;
            sh3_reg     <= '0;
            diff1_reg   <= '0;
            diff2_reg   <= '0;
            diff3_reg   <= '0;
`ifdef SUBS3_FLAGS_EN
            neg1_reg    <= 1'b0;
            neg2_reg    <= 1'b0;
            neg3_reg    <= 1'b0;
            zero3_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg       <= D3W'(bus.a);
                        b_reg       <= D3W'(bus.b);
                        c_reg       <= D3W'(bus.c);
                        d_reg       <= D3W'(bus.d);
                        cnt_reg     <= '0;
                        borrow1_reg <= 1'b0;
                        borrow2_reg <= 1'b0;
                        borrow3_reg <= 1'b0;
                    end
                end
                SUB12: begin
                    sh2_reg     <= {s2[0], sh2_reg[D2W-1:1]};
                    borrow2_reg <= s2[1];
                    // Lane 1 is narrower and simply holds once its bits are done
                    if (lane1_active) begin
                        sh1_reg     <= {s1[0], sh1_reg[D1W-1:1]};
                        borrow1_reg <= s1[1];
                    end
                    cnt_reg <= (cnt_reg == LAST2) ? '0 : cnt_reg + 1'b1;
                end
                SUB3: begin
                    sh3_reg     <= sh3_final;
                    borrow3_reg <= s3[1];
                    cnt_reg     <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST3) begin
                        cnt_reg   <= '0;
                        diff1_reg <= sh1_reg;
                        diff2_reg <= sh2_reg;
                        diff3_reg <= sh3_final;
`ifdef SUBS3_FLAGS_EN
                        neg1_reg  <= sh1_reg[D1W-1];
                        neg2_reg  <= sh2_reg[D2W-1];
                        neg3_reg  <= sh3_final[D3W-1];
                        zero3_reg <= (sh3_final == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.diff1     = diff1_reg;
    assign bus.diff2     = diff2_reg;
    assign bus.diff3     = diff3_reg;
`ifdef SUBS3_FLAGS_EN
    assign bus.neg1      = neg1_reg;
    assign bus.neg2      = neg2_reg;
    assign bus.neg3      = neg3_reg;
    assign bus.zero3     = zero3_reg;
`endif
endmodule

// File: tb/tb_subs3_serial.sv
`timescale 1ns/1ps
// Scoreboard bench for subs3_serial: driver pushes hand-computed results, monitor pops on each output handshake.
module tb_subs3_serial;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    subs3_serial_if #(.W1(4), .W2(8)) bus ();

    subs3_serial #(.W1(4), .W2(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0] d1;
        logic [8:0] d2;
        logic [9:0] d3;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_out = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Monitor: compare on every output handshake
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            n_out++;
            $display("out %0d: diff1=%h diff2=%h diff3=%h", n_out, bus.diff1, bus.diff2, bus.diff3);
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff1", 32'(bus.diff1), 32'(e.d1));
                check("diff2", 32'(bus.diff2), 32'(e.d2));
                check("diff3", 32'(bus.diff3), 32'(e.d3));
`ifdef SUBS3_FLAGS_EN
                check("neg1", 32'(bus.neg1), 32'(e.d1[4]));
                check("neg2", 32'(bus.neg2), 32'(e.d2[8]));
                check("neg3", 32'(bus.neg3), 32'(e.d3[9]));
                check("zero3", 32'(bus.zero3), 32'(e.d3 == 10'd0));
`endif
            end
        end
    end

    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          input logic [4:0] e1, input logic [8:0] e2, input logic [9:0] e3,
                          input int stall, input bit holdoff);
        exp_t e;
        int   edges;
        int   waits;
        waits = 0;
        while (!bus.in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        @(negedge clk);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.a = a; bus.b = b; bus.c = c; bus.d = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        e.d1 = e1; e.d2 = e2; e.d3 = e3;
        sb.push_back(e);
        $display("in: a=%0d b=%0d c=%0d d=%0d stall=%0d holdoff=%0d", a, b, c, d, stall, holdoff);
        @(posedge clk); #1;
        edges = 0;
        while (!bus.out_valid && edges < 40) begin
            if (holdoff) begin
                bus.in_valid = 1'b1;
                bus.a = 4'($urandom); bus.b = 4'($urandom);
                bus.c = 8'($urandom); bus.d = 8'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            if (edges == 5) check("busy_in_ready", 32'(bus.in_ready), 32'd0);
        end
        check("latency", 32'(edges), 32'd19);
        for (int i = 0; i < stall; i++) begin
            check("stall_diff1", 32'(bus.diff1), 32'(e1));
            check("stall_diff2", 32'(bus.diff2), 32'(e2));
            check("stall_diff3", 32'(bus.diff3), 32'(e3));
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_abort();
        bit saw;
        @(negedge clk);
        bus.a = 4'd5; bus.b = 4'd2; bus.c = 8'd200; bus.d = 8'd100;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        $display("in: a=5 b=2 c=200 d=100 (reset at edge 7)");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_diff1", 32'(bus.diff1), 32'd0);
        check("abort_diff2", 32'(bus.diff2), 32'd0);
        check("abort_diff3", 32'(bus.diff3), 32'd0);
        saw = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            saw = saw | bus.out_valid;
        end
        check("abort_no_valid", 32'(saw), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff1", 32'(bus.diff1), 32'd0);
        check("rst_diff2", 32'(bus.diff2), 32'd0);
        check("rst_diff3", 32'(bus.diff3), 32'd0);
`ifdef SUBS3_FLAGS_EN
        check("rst_zero3", 32'(bus.zero3), 32'd0);
`endif
        reset = 1'b0;

        run_op(4'd0,  4'd3,  8'd1,   8'd255, 5'h1D, 9'h102, 10'h305, 0, 1'b0);
        run_op(4'd10, 4'd13, 8'd9,   8'd10,  5'h1D, 9'h1FF, 10'h002, 5, 1'b0);
        run_op(4'd15, 4'd15, 8'd109, 8'd37,  5'h00, 9'h048, 10'h048, 0, 1'b0);
        run_op(4'd0,  4'd9,  8'd45,  8'd45,  5'h17, 9'h000, 10'h009, 0, 1'b0);
        run_op(4'd0,  4'd15, 8'd255, 8'd0,   5'h11, 9'h0FF, 10'h10E, 0, 1'b0);
        run_op(4'd15, 4'd0,  8'd0,   8'd255, 5'h0F, 9'h101, 10'h2F2, 0, 1'b0);
        run_abort();
        run_op(4'd7,  4'd1,  8'd20,  8'd30,  5'h06, 9'h1F6, 10'h3F0, 0, 1'b0);
        run_op(4'd3,  4'd12, 8'd100, 8'd7,   5'h17, 9'h05D, 10'h066, 3, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("out_count", 32'(n_out), 32'd8);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1, "timeout");
    end
endmodule
